sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter and sequencer for the single-port-pair `simple_sram` (registered read address, two-stage registered write). Two requesters, A and B, each issue one read or write per handshake. The block grants at most one operation per cycle, drives the SRAM ports from registers, and routes read data back to the requester that issued the read. It sits between compute/DMA-style clients and the SRAM instance.

## Interface
- `addr_width`, default 11: SRAM address width; must match the SRAM instance.
- `data_width`, default 32: data width; signed data is passed through unchanged.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `a_req_valid` in 1: A has a request.
- `a_req_ready` out 1: A's request is accepted this cycle.
- `a_req_write` in 1: 1 = write, 0 = read.
- `a_req_addr` in `addr_width`: request address.
- `a_req_wdata` in `data_width`: write data.
- `a_rsp_valid` out 1: A's read data is valid this cycle.
- `a_rsp_rdata` out `data_width`: A's read data.
- `b_*`: identical set for requester B.
- `sram_raddr` out `addr_width`: SRAM read address.
- `sram_waddr` out `addr_width`: SRAM write address.
- `sram_write` out 1: SRAM write enable.
- `sram_din` out `data_width`: SRAM write data.
- `sram_dout` in `data_width`: SRAM read data.

## Operation
- Handshake:
  - A request is accepted in a cycle where `x_req_valid && x_req_ready`.
  - `x_req_ready` may depend combinationally on the valid signals.
  - A requester holds its valid, write, addr and wdata stable until accepted.
- Grant:
  - At most one of `a_req_ready` / `b_req_ready` is high per cycle.
  - The block never stalls: a lone valid requester is always granted.
- Both valid in the same cycle:
  - Resolved per Configuration.
- Issue stage, registered, the cycle after acceptance:
  - Write: `sram_waddr` = addr, `sram_din` = wdata, `sram_write` = 1.
  - Read: `sram_raddr` = addr, `sram_write` = 0.
  - Idle cycle: `sram_write` = 0; `sram_raddr`, `sram_waddr` and `sram_din` hold their last values.
- Response stages:
  - Each read carries a requester tag (A/B) through a valid/tag shift pipeline.
  - `sram_dout` is sampled into the rsp register of the tagged requester.
  - Writes produce no response.
- Responses have no backpressure. Each `rsp_valid` is a single-cycle pulse; `rsp_rdata` holds until the next response to that requester.
- Reset (`rst_n` = 0 at an edge):
  - All pipeline valids and tags clear; in-flight reads are dropped and never respond.
  - `sram_write` = 0, both ready = 0, both `rsp_valid` = 0.
  - `sram_raddr`, `sram_waddr` = 0; `sram_din` and both `rsp_rdata` = 0.
  - The round-robin pointer is set to "B last", so A wins first.
  - The SRAM contents are untouched.

## Timing
Cycle T is the acceptance cycle.
- Read:
  - `sram_raddr` is valid in T+1.
  - The SRAM buffers the address at the end of T+1, so `sram_dout` is valid in T+2.
  - Data is registered at the end of T+2; `x_rsp_valid` = 1 in T+3. Fixed read latency: 3.
- Write:
  - `sram_write` = 1 in T+1.
  - The SRAM memory updates at the end of T+2.
- Read-after-write ordering:
  - A read accepted in any cycle ≥ T+1 after a write accepted in T returns the new data.
  - This holds from either requester, with no stall or forwarding. The read samples memory in ≥ T+3, after the update at the end of T+2.
- Throughput:
  - One operation per cycle in total.
  - Back-to-back reads give back-to-back responses, in acceptance order.
- Ready timing:
  - `x_req_ready` is high in the same cycle as `x_req_valid` when granted. There are no idle bubbles between grants.

## Configuration
- Macro `SRAM_ARB_RR_EN`:
  - Defined: round-robin. When both are valid, grant the requester not granted most recently. The pointer updates only on an accepted handshake.
  - Undefined: fixed priority, A always wins a conflict. B may starve; the pointer register is absent.

## Test plan
- Reset, then A writes 0x0000_1234 to addr 5 at T → `sram_write` = 1, `sram_waddr` = 5, `sram_din` = 0x1234 in T+1; no `a_rsp_valid`.
- A writes 0xDEAD_BEEF to addr 7 at T, B reads addr 7 at T+1 → `b_rsp_valid` pulses in T+4 with 0xDEADBEEF; `a_rsp_valid` stays 0.
- A and B both hold read requests (A addr 1, B addr 2) for 4 cycles:
  - With `SRAM_ARB_RR_EN`: grants go A, B, A, B.
  - Without it: A, A, A, A, and `b_req_ready` stays 0.
- A issues 3 back-to-back reads of addrs 0, 1, 2 preloaded with 10, 11, 12 → `a_rsp_valid` is high for 3 consecutive cycles starting T+3, with data 10, 11, 12.
- A read accepted at T, `rst_n` = 0 at the T+1 edge → no `rsp_valid` in T+2..T+5, all outputs at their reset values, and the next read after reset returns correct memory data.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Request/response and SRAM-side signal bundle for sram_arbiter.
// slave = the arbiter; master = the requesters plus the SRAM instance.
interface sram_arbiter_if #(
    parameter int addr_width = 11,
    parameter int data_width = 32
);
    logic                  a_req_valid;
    logic                  a_req_ready;
    logic                  a_req_write;
    logic [addr_width-1:0] a_req_addr;
    logic [data_width-1:0] a_req_wdata;
    logic                  a_rsp_valid;
    logic [data_width-1:0] a_rsp_rdata;

    logic                  b_req_valid;
    logic                  b_req_ready;
    logic                  b_req_write;
    logic [addr_width-1:0] b_req_addr;
    logic [data_width-1:0] b_req_wdata;
    logic                  b_rsp_valid;
    logic [data_width-1:0] b_rsp_rdata;

    logic [addr_width-1:0] sram_raddr;
    logic [addr_width-1:0] sram_waddr;
    logic                  sram_write;
    logic [data_width-1:0] sram_din;
    logic [data_width-1:0] sram_dout;

    modport slave (
        input  a_req_valid, a_req_write, a_req_addr, a_req_wdata,
        output a_req_ready, a_rsp_valid, a_rsp_rdata,
        input  b_req_valid, b_req_write, b_req_addr, b_req_wdata,
        output b_req_ready, b_rsp_valid, b_rsp_rdata,
        output sram_raddr, sram_waddr, sram_write, sram_din,
        input  sram_dout
    );

    modport master (
        output a_req_valid, a_req_write, a_req_addr, a_req_wdata,
        input  a_req_ready, a_rsp_valid, a_rsp_rdata,
        output b_req_valid, b_req_write, b_req_addr, b_req_wdata,
        input  b_req_ready, b_rsp_valid, b_rsp_rdata,
        input  sram_raddr, sram_waddr, sram_write, sram_din,
        output sram_dout
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter/sequencer for simple_sram; fixed read latency of 3.
// Define SRAM_ARB_RR_EN for round-robin conflict resolution (default: A has fixed priority).
module sram_arbiter #(
    parameter int addr_width = 11,
    parameter int data_width = 32
) (
    input logic         clk,
    input logic         rst_n,
    sram_arbiter_if.slave bus
);
    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_tag_e;

    logic a_grant, b_grant;

`ifdef SRAM_ARB_RR_EN
    logic last_b_q, last_b_d;

    always_comb begin
        a_grant  = rst_n && bus.a_req_valid && (!bus.b_req_valid || last_b_q);
        b_grant  = rst_n && bus.b_req_valid && (!bus.a_req_valid || !last_b_q);
        last_b_d = last_b_q;
        if (a_grant)      last_b_d = 1'b0;
        else if (b_grant) last_b_d = 1'b1;
    end

    // Reset leaves "B last" so A wins the first conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) last_b_q <= 1'b1;
        else        last_b_q <= last_b_d;
    end
`else
    always_comb begin
        a_grant = rst_n && bus.a_req_valid;
        b_grant = rst_n && bus.b_req_valid && !bus.a_req_valid;
    end
`endif

    assign bus.a_req_ready = a_grant;
    assign bus.b_req_ready = b_grant;

    logic                  acc_valid, acc_write;
    logic [addr_width-1:0] acc_addr;
    logic [data_width-1:0] acc_wdata;

    // NOTE: every variable gets a default at the top of an always_comb so no latch is inferred.
    always_comb begin
        acc_valid = a_grant || b_grant;
        acc_write = b_grant ? bus.b_req_write : bus.a_req_write;
        acc_addr  = b_grant ? bus.b_req_addr  : bus.a_req_addr;
        acc_wdata = b_grant ? bus.b_req_wdata : bus.a_req_wdata;
    end

    logic [addr_width-1:0] sram_raddr_q, sram_raddr_d;
    logic [addr_width-1:0] sram_waddr_q, sram_waddr_d;
    logic [data_width-1:0] sram_din_q,   sram_din_d;
    logic                  sram_write_q, sram_write_d;
    logic                  rd1_valid_q,  rd1_valid_d;
    req_tag_e              rd1_tag_q,    rd1_tag_d;
    logic                  rd2_valid_q,  rd2_valid_d;
    req_tag_e              rd2_tag_q,    rd2_tag_d;
    logic                  a_rsp_valid_q, a_rsp_valid_d;
    logic [data_width-1:0] a_rsp_rdata_q, a_rsp_rdata_d;
    logic                  b_rsp_valid_q, b_rsp_valid_d;
    logic [data_width-1:0] b_rsp_rdata_q, b_rsp_rdata_d;

    always_comb begin
        sram_raddr_d = sram_raddr_q;
        sram_waddr_d = sram_waddr_q;
        sram_din_d   = sram_din_q;
        sram_write_d = acc_valid && acc_write;
        if (acc_valid && acc_write) begin
            sram_waddr_d = acc_addr;
            sram_din_d   = acc_wdata;
        end
        if (acc_valid && !acc_write) sram_raddr_d = acc_addr;

        // Read tag pipeline: issue stage, then the cycle sram_dout is valid.
        rd1_valid_d = acc_valid && !acc_write;
        rd1_tag_d   = b_grant ? REQ_B : REQ_A;
        rd2_valid_d = rd1_valid_q;
        rd2_tag_d   = rd1_tag_q;

        a_rsp_valid_d = rd2_valid_q && (rd2_tag_q == REQ_A);
        b_rsp_valid_d = rd2_valid_q && (rd2_tag_q == REQ_B);
        a_rsp_rdata_d = a_rsp_valid_d ? bus.sram_dout : a_rsp_rdata_q;
        b_rsp_rdata_d = b_rsp_valid_d ? bus.sram_dout : b_rsp_rdata_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sram_raddr_q  <= '0;
            sram_waddr_q  <= '0;
            sram_din_q    <= '0;
            sram_write_q  <= 1'b0;
            rd1_valid_q   <= 1'b0;
            rd1_tag_q     <= REQ_A;
            rd2_valid_q   <= 1'b0;
            rd2_tag_q     <= REQ_A;
            a_rsp_valid_q <= 1'b0;
            a_rsp_rdata_q <= '0;
            b_rsp_valid_q <= 1'b0;
            b_rsp_rdata_q <= '0;
        end else begin
            sram_raddr_q  <= sram_raddr_d;
            sram_waddr_q  <= sram_waddr_d;
            sram_din_q    <= sram_din_d;
            sram_write_q  <= sram_write_d;
            rd1_valid_q   <= rd1_valid_d;
            rd1_tag_q     <= rd1_tag_d;
            rd2_valid_q   <= rd2_valid_d;
            rd2_tag_q     <= rd2_tag_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            a_rsp_rdata_q <= a_rsp_rdata_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            b_rsp_rdata_q <= b_rsp_rdata_d;
        end
    end

    assign bus.sram_raddr  = sram_raddr_q;
    assign bus.sram_waddr  = sram_waddr_q;
    assign bus.sram_din    = sram_din_q;
    assign bus.sram_write  = sram_write_q;
    assign bus.a_rsp_valid = a_rsp_valid_q;
    assign bus.a_rsp_rdata = a_rsp_rdata_q;
    assign bus.b_rsp_valid = b_rsp_valid_q;
    assign bus.b_rsp_rdata = b_rsp_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural simple_sram model.
// Follows SRAM_ARB_RR_EN for the conflict-grant expectations.
module tb_sram_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    sram_arbiter_if #(.addr_width(AW), .data_width(DW)) bus ();

    sram_arbiter #(.addr_width(AW), .data_width(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // simple_sram: registered read address, write registered then committed one edge later.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] m_raddr_q, m_waddr_q;
    logic [DW-1:0] m_din_q;
    logic          m_we_q;

    always @(posedge clk) begin
        m_raddr_q <= bus.sram_raddr;
        m_waddr_q <= bus.sram_waddr;
        m_din_q   <= bus.sram_din;
        m_we_q    <= bus.sram_write;
        if (m_we_q) mem[m_waddr_q] <= m_din_q;
    end
    assign bus.sram_dout = mem[m_raddr_q];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.a_req_valid = 1'b0;
        bus.b_req_valid = 1'b0;
    endtask

    task automatic drive_a(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.a_req_valid = 1'b1;
        bus.a_req_write = wr;
        bus.a_req_addr  = addr;
        bus.a_req_wdata = wdata;
    endtask

    task automatic drive_b(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.b_req_valid = 1'b1;
        bus.b_req_write = wr;
        bus.b_req_addr  = addr;
        bus.b_req_wdata = wdata;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_sram_write"}, 64'(bus.sram_write), 64'd0);
        check({pfx, "_sram_raddr"}, 64'(bus.sram_raddr), 64'd0);
        check({pfx, "_sram_waddr"}, 64'(bus.sram_waddr), 64'd0);
        check({pfx, "_sram_din"},   64'(bus.sram_din),   64'd0);
        check({pfx, "_a_rdata"},    64'(bus.a_rsp_rdata), 64'd0);
        check({pfx, "_b_rdata"},    64'(bus.b_rsp_rdata), 64'd0);
        check({pfx, "_a_rsp"},      64'(bus.a_rsp_valid), 64'd0);
        check({pfx, "_b_rsp"},      64'(bus.b_rsp_valid), 64'd0);
    endtask

`ifdef SRAM_ARB_RR_EN
    localparam logic [3:0] EXP_A_GRANT = 4'b0101; // bit i = cycle i
`else
    localparam logic [3:0] EXP_A_GRANT = 4'b1111;
`endif

    initial begin
        logic [3:0] exp_a;
        exp_a = EXP_A_GRANT;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[0] = 32'd10;
        mem[1] = 32'd11;
        mem[2] = 32'd12;

        bus.a_req_valid = 1'b0; bus.a_req_write = 1'b0; bus.a_req_addr = '0; bus.a_req_wdata = '0;
        bus.b_req_valid = 1'b0; bus.b_req_write = 1'b0; bus.b_req_addr = '0; bus.b_req_wdata = '0;
        rst_n = 1'b0;

        // Reset: readies must stay low even with valids asserted.
        step();
        step();
        drive_a(1'b0, 11'd3, '0);
        drive_b(1'b0, 11'd4, '0);
        @(negedge clk);
        check("rst_a_ready", 64'(bus.a_req_ready), 64'd0);
        check("rst_b_ready", 64'(bus.b_req_ready), 64'd0);
        check_reset_outputs("rst");
        step();
        idle_all();
        rst_n = 1'b1;

        // A write 0x1234 -> addr 5.
        step();
        drive_a(1'b1, 11'd5, 32'h0000_1234);
        @(negedge clk);
        check("wr_a_ready", 64'(bus.a_req_ready), 64'd1);
        step();
        idle_all();
        @(negedge clk);
        check("wr_sram_write", 64'(bus.sram_write), 64'd1);
        check("wr_sram_waddr", 64'(bus.sram_waddr), 64'd5);
        check("wr_sram_din",   64'(bus.sram_din),   64'h1234);
        check("wr_a_rsp_t1",   64'(bus.a_rsp_valid), 64'd0);
        for (int c = 2; c <= 4; c++) begin
            step();
            @(negedge clk);
            check($sformatf("wr_sram_write_t%0d", c), 64'(bus.sram_write), 64'd0);
            check($sformatf("wr_a_rsp_t%0d", c), 64'(bus.a_rsp_valid), 64'd0);
        end
        check("wr_waddr_hold", 64'(bus.sram_waddr), 64'd5);

        // A writes 0xDEADBEEF to 7 at T, B reads 7 at T+1.
        step();
        drive_a(1'b1, 11'd7, 32'hDEAD_BEEF);
        step();
        idle_all();
        drive_b(1'b0, 11'd7, '0);
        @(negedge clk);
        check("raw_b_ready", 64'(bus.b_req_ready), 64'd1);
        for (int c = 2; c <= 5; c++) begin
            step();
            idle_all();
            @(negedge clk);
            check($sformatf("raw_b_rsp_t%0d", c), 64'(bus.b_rsp_valid), (c == 4) ? 64'd1 : 64'd0);
            check($sformatf("raw_a_rsp_t%0d", c), 64'(bus.a_rsp_valid), 64'd0);
            if (c == 4) check("raw_b_rdata", 64'(bus.b_rsp_rdata), 64'hDEAD_BEEF);
        end
        check("raw_b_rdata_hold", 64'(bus.b_rsp_rdata), 64'hDEAD_BEEF);

        // Conflict: both hold reads for 4 cycles (last grant was B).
        for (int c = 0; c < 4; c++) begin
            step();
            drive_a(1'b0, 11'd1, '0);
            drive_b(1'b0, 11'd2, '0);
            @(negedge clk);
            check($sformatf("arb_a_ready_c%0d", c), 64'(bus.a_req_ready), 64'(exp_a[c]));
            check($sformatf("arb_b_ready_c%0d", c), 64'(bus.b_req_ready), 64'(!exp_a[c]));
        end
        step();
        idle_all();
        for (int c = 0; c < 4; c++) step();

        // Back-to-back A reads of 0,1,2.
        for (int c = 0; c <= 6; c++) begin
            step();
            if (c < 3) drive_a(1'b0, AW'(c), '0);
            else idle_all();
            @(negedge clk);
            if (c >= 3) begin
                check($sformatf("b2b_a_rsp_t%0d", c), 64'(bus.a_rsp_valid), (c < 6) ? 64'd1 : 64'd0);
                if (c < 6) check($sformatf("b2b_a_rdata_t%0d", c), 64'(bus.a_rsp_rdata), 64'(10 + c - 3));
                check($sformatf("b2b_b_rsp_t%0d", c), 64'(bus.b_rsp_valid), 64'd0);
            end
        end

        // Read accepted at T, reset at the edge ending T+1: the read must vanish.
        step();
        drive_a(1'b0, 11'd5, '0);
        step();
        idle_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid");
        for (int c = 3; c <= 5; c++) begin
            step();
            @(negedge clk);
            check($sformatf("mid_a_rsp_t%0d", c), 64'(bus.a_rsp_valid), 64'd0);
            check($sformatf("mid_b_rsp_t%0d", c), 64'(bus.b_rsp_valid), 64'd0);
        end

        // Memory survives reset.
        step();
        drive_a(1'b0, 11'd7, '0);
        step();
        idle_all();
        step();
        step();
        @(negedge clk);
        check("post_a_rsp",   64'(bus.a_rsp_valid), 64'd1);
        check("post_a_rdata", 64'(bus.a_rsp_rdata), 64'hDEAD_BEEF);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
